// File: rtl/reg_store_unit.sv
// Store path: queues {addr, data} snapshots of acc/temp and writes them over req/ack.
// Optional request timeout with sticky err: define STORE_TIMEOUT_EN.
`timescale 1ns/1ps
module reg_store_unit #(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic                     st_sel,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [7:0]               acc_in,
  input  logic [7:0]               temp_in,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic                     mem_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  input  logic                     err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [7:0]        q_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  state_t            state;
  logic              push;
  logic              pop;
  logic              done;
  logic              tmo;

  assign st_ready = count < CW'(DEPTH);
  assign push     = st_valid && st_ready;
  assign busy     = count != '0;
  assign done     = (state == REQ) && mem_ack;
  assign pop      = done || tmo;

  // Entry stays queued while in flight, so count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= st_addr;
      q_data[wr_ptr] <= st_sel ? temp_in : acc_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            mem_req   <= 1'b1;
            mem_addr  <= q_addr[rd_ptr];
            mem_wdata <= q_data[rd_ptr];
            state     <= REQ;
          end
        end
        REQ: begin
          if (pop) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STORE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo = (state == REQ) && !mem_ack &&
               (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state != REQ) tmo_cnt <= '0;
      else if (!pop)    tmo_cnt <= tmo_cnt + TW'(1);
      // set beats clear on the same edge
      if (tmo)          err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end
`else
  logic unused_cfg;
  localparam int unused_tmo = TIMEOUT_CYCLES;

  assign tmo        = 1'b0;
  assign err        = 1'b0;
  assign unused_cfg = err_clr;
`endif

endmodule

// File: doc/reg_store_unit.md
# reg_store_unit

Store path for the 8-bit processor's externally controllable registers. On a store command it snapshots the accumulator or temp register, queues the address/data pair, and writes it to data memory over a req/ack handshake. It sits between the control unit, the register outputs (`acc_out`, `temp_out`) and the memory write port, so a store never stalls the register datapath unless the queue is full.

## Interface
- `ADDR_W`, 8: memory address width.
- `DEPTH`, 2: store queue entries; power of two, ≥2.
- `TIMEOUT_CYCLES`, 16: cycles `mem_req` may wait for `mem_ack` before abort. Only used with `STORE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `st_valid`  in  1  store command valid.
- `st_ready`  out  1  queue can accept a command.
- `st_sel`  in  1  source select: 0 = accumulator, 1 = temp.
- `st_addr`  in  ADDR_W  target memory address.
- `acc_in`  in  8  accumulator register output.
- `temp_in`  in  8  temp register output.
- `mem_req`  out  1  memory write request.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  8  write data.
- `mem_ack`  in  1  memory write accepted.
- `busy`  out  1  queue non-empty or request outstanding.
- `count`  out  $clog2(DEPTH)+1  queued entries, including the in-flight entry.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err`.

## Operation
- Accept on the rising edge where `st_valid && st_ready`.
- Data is sampled at the accept edge from `st_sel ? temp_in : acc_in`. This is the pre-edge register value, so a simultaneous register load is not captured.
- `{st_addr, data}` is pushed to the FIFO tail.
- `st_ready = (count < DEPTH)`. It is registered-state only, with no combinational path from `mem_ack`. When full, a same-cycle pop does not enable a push.
- FSM:
  - IDLE: if FIFO is non-empty, register the head onto `mem_addr`/`mem_wdata`, set `mem_req`=1, go to REQ.
  - REQ: hold `mem_req`, `mem_addr` and `mem_wdata` stable. On an edge where `mem_ack`=1, pop the head, clear `mem_req`, go to IDLE.
- `mem_ack` is ignored while `mem_req`=0.
- `count` increments on push and decrements on pop. Simultaneous push and pop leaves it unchanged.
- `busy = (count != 0)`.
- Pointers wrap modulo DEPTH.
- Reset values: `mem_req`=0, `mem_addr`=0, `mem_wdata`=0, `count`=0, `st_ready`=1, `busy`=0, `err`=0. The FSM is in IDLE and the FIFO is empty.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous), queued stores are discarded, and no partial write is retried.

## Timing
- Empty and idle, accept at edge N: `mem_req` is high after edge N+1, with `mem_addr`/`mem_wdata` valid in that same cycle.
- `mem_ack` high at edge M: `mem_req` is low after M. The next queued entry's `mem_req` is high after M+1. This gives a one-cycle gap between requests and a peak of 1 store per 2 cycles with zero-wait ack.
- `st_ready` reasserts the cycle after a pop from a full queue.
- Outputs are all registered or decoded from registered state only.

## Configuration
- `STORE_TIMEOUT_EN` defined:
  - A counter runs in REQ, cleared on entry.
  - If `mem_ack` is not seen within `TIMEOUT_CYCLES` cycles, the unit aborts. At the edge completing cycle `TIMEOUT_CYCLES` it pops the entry, clears `mem_req`, sets `err`=1 and goes to IDLE.
  - `mem_ack` on that same edge counts as success: no error.
  - `err_clr` clears `err`. If set and clear occur on the same edge, set wins.
- Undefined: no counter. REQ waits indefinitely, `err` is tied to 0 and `err_clr` is ignored.

## Test plan
- Single store: after reset, `acc_in`=0x5A, `st_sel`=0, `st_addr`=0x10, accept at edge N; ack one cycle after `mem_req` rises -> `mem_req` after N+1 with addr 0x10, data 0x5A; `busy` falls after the ack edge.
- Snapshot: accept with `temp_in`=0x33 and `st_sel`=1 while `temp_in` changes to 0xFF on the same edge; delay ack 3 cycles -> `mem_wdata`=0x33 held stable until the ack.
- Full/backpressure: hold `mem_ack`=0 and issue 3 stores (0x01, 0x02, 0x03) -> `st_ready`=0 after 2 accepts, `count`=2; after an ack, entries 0x01 then 0x02 issue in order and the third is accepted once `st_ready` rises.
- Reset mid-request: `mem_req`=1 with 2 entries queued, drive `reset`=0 asynchronously -> `mem_req`=0 immediately, `count`=0, `st_ready`=1, no write after release.
- Timeout (`STORE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16): never ack -> `mem_req` drops after 16 cycles in REQ, `err`=1 and the next entry issues; `err_clr` pulse -> `err`=0; ack on the 16th edge -> `err` stays 0.
